sequential_divider: RTL and testbench

- Sequential fixed-point ratio unit. On a `sample_now` strobe it computes `q_out = min(255, floor(oscillator_out * 256 / divisor))`.
- The result is an 8-bit fraction of full scale.
- Sits between an oscillator/counter stage (source of `oscillator_out`) and the note/divisor select logic (source of `divisor`).
- Uses a restoring shift-subtract divider, one quotient bit per clock; `q_out` holds the last completed result.

---
 rtl/sequential_divider.sv | 96 +++++++++
 tb/tb_sequential_divider.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - restoring shift-subtract ratio unit, q_out = min(255, osc*256/divisor)
module sequential_divider #(
   parameter int IN_W = 16,
   parameter int Q_W  = 8
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            sample_now,
   input  logic [IN_W-1:0] divisor,
   input  logic [IN_W-1:0] oscillator_out,
   output logic [Q_W-1:0]  q_out
);
   localparam int R_W = IN_W + 1;
   localparam int C_W = $clog2(Q_W + 1);
   localparam logic [C_W-1:0] LAST_CNT = C_W'(Q_W - 1);

   typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

   state_t          state_q, state_d;
   logic [R_W-1:0]  rem_q, rem_d;
   logic [IN_W-1:0] den_q, den_d;
   logic [Q_W-1:0]  quo_q, quo_d;
   logic [C_W-1:0]  cnt_q, cnt_d;
   logic            sat_q, sat_d;
   logic [Q_W-1:0]  q_out_q, q_out_d;

   logic [R_W-1:0]  rem_shift;
   logic [R_W-1:0]  den_ext;
   logic            quo_bit;

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      den_d     = den_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      q_out_d   = q_out_q;
      rem_shift = {rem_q[R_W-2:0], 1'b0};
      den_ext   = {1'b0, den_q};
      quo_bit   = 1'b0;
      case (state_q)
         IDLE: begin
            if (sample_now) begin
               rem_d   = {1'b0, oscillator_out};
               den_d   = divisor;
               quo_d   = '0;
               cnt_d   = '0;
               // Quotient would not fit in Q_W fractional bits; iterations still run for fixed latency.
               sat_d   = (divisor == '0) || (oscillator_out >= divisor);
               state_d = DIVIDE;
            end
         end
         DIVIDE: begin
            if (rem_shift >= den_ext) begin
               rem_d   = rem_shift - den_ext;
               quo_bit = 1'b1;
            end else begin
               rem_d   = rem_shift;
            end
            quo_d = {quo_q[Q_W-2:0], quo_bit};
            cnt_d = cnt_q + C_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            q_out_d = sat_q ? '1 : quo_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         den_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         q_out_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         den_q   <= den_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         q_out_q <= q_out_d;
      end
   end

   assign q_out = q_out_q;
endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - scoreboard bench for sequential_divider with arithmetic reference model
`timescale 1ns/100ps
module tb_sequential_divider;
   logic        clk = 1'b0;
   logic        nrst;
   logic        sample_now;
   logic [15:0] divisor;
   logic [15:0] oscillator_out;
   logic [7:0]  q_out;

   sequential_divider #(.IN_W(16), .Q_W(8)) dut (
      .clk(clk),
      .nrst(nrst),
      .sample_now(sample_now),
      .divisor(divisor),
      .oscillator_out(oscillator_out),
      .q_out(q_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] exp;
      string      tag;
   } chk_t;

   chk_t       sb[$];
   chk_t       mon_c;
   int         edge_cnt = 0;
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] prev_res = 8'd0;

   always @(posedge clk) edge_cnt++;

   // Expected q_out entries become due once the given rising edge has occurred.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
         mon_c = sb.pop_front();
         checks++;
         if (q_out !== mon_c.exp) begin
            failures++;
            $display("FAIL %s edge=%0d q_out=%0d expected=%0d", mon_c.tag, edge_cnt, q_out, mon_c.exp);
         end
      end
   end

   function automatic logic [7:0] ref_div(input logic [15:0] n, input logic [15:0] d);
      longint unsigned r;
      if (d == 16'd0) return 8'hFF;
      r = (longint'(n) * 256) / longint'(d);
      if (r > 255) return 8'hFF;
      return r[7:0];
   endfunction

   task automatic push(input int cyc, input logic [7:0] exp, input string tag);
      chk_t c;
      c.cyc = cyc;
      c.exp = exp;
      c.tag = tag;
      sb.push_back(c);
   endtask

   task automatic wait_until(input int cyc);
      while (edge_cnt < cyc) @(negedge clk);
   endtask

   task automatic start_div(input logic [15:0] n, input logic [15:0] d, input bit scramble, output int e0);
      @(negedge clk);
      divisor        = d;
      oscillator_out = n;
      sample_now     = 1'b1;
      e0             = edge_cnt + 1;
      @(negedge clk);
      sample_now = 1'b0;
      if (scramble) begin
         divisor        = 16'($urandom);
         oscillator_out = 16'($urandom);
      end
   endtask

   task automatic run_div(input logic [15:0] n, input logic [15:0] d, input bit scramble, input string tag);
      int e0;
      logic [7:0] exp;
      exp = ref_div(n, d);
      start_div(n, d, scramble, e0);
      push(e0 + 5, prev_res, {tag, "_hold5"});
      push(e0 + 8, prev_res, {tag, "_hold8"});
      push(e0 + 9, exp, tag);
      prev_res = exp;
      wait_until(e0 + 9);
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog edge=%0d pending=%0d expected=0", edge_cnt, sb.size());
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int e0;
      logic [7:0] exp;
      logic [15:0] n, d;
      nrst           = 1'b0;
      sample_now     = 1'b0;
      divisor        = 16'd0;
      oscillator_out = 16'd0;
      push(1, 8'd0, "rst_held1");
      push(2, 8'd0, "rst_held2");
      push(3, 8'd0, "rst_release1");
      push(4, 8'd0, "rst_release2");
      wait_until(2);
      nrst = 1'b1;
      wait_until(4);

      run_div(16'd22000, 16'd22727, 1'b0, "basic_247");
      run_div(16'd22256, 16'd22727, 1'b0, "next_250");
      run_div(16'd22727, 16'd22727, 1'b0, "equal_255");
      run_div(16'd0,     16'd22727, 1'b0, "zero_num");
      run_div(16'd40000, 16'd22727, 1'b1, "over_255");
      run_div(16'd5,     16'd0,     1'b1, "div0_255");
      run_div(16'd1,     16'd65535, 1'b1, "tiny_0");
      run_div(16'd65534, 16'd65535, 1'b1, "max_255_lim");

      // Second strobe with different operands mid-division must be ignored.
      exp = ref_div(16'd22000, 16'd22727);
      start_div(16'd22000, 16'd22727, 1'b0, e0);
      push(e0 + 2, prev_res, "mid_strobe_hold");
      wait_until(e0 + 2);
      divisor        = 16'd100;
      oscillator_out = 16'd50;
      sample_now     = 1'b1;
      @(negedge clk);
      sample_now = 1'b0;
      push(e0 + 9, exp, "mid_strobe_result");
      push(e0 + 12, exp, "mid_strobe_norestart");
      prev_res = exp;
      wait_until(e0 + 12);

      // Reset during iteration aborts the division and leaves q_out at zero.
      start_div(16'd1000, 16'd3000, 1'b0, e0);
      push(e0 + 3, prev_res, "pre_abort_hold");
      wait_until(e0 + 3);
      @(posedge clk);
      #1 nrst = 1'b0;
      push(e0 + 4, 8'd0, "abort_immediate");
      push(e0 + 6, 8'd0, "abort_held");
      push(e0 + 9, 8'd0, "abort_no_update9");
      push(e0 + 11, 8'd0, "abort_no_update11");
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      wait_until(e0 + 11);
      prev_res = 8'd0;

      for (int i = 0; i < 30; i++) begin
         d = 16'($urandom);
         case ($urandom_range(0, 3))
            0: n = (d == 16'd0) ? 16'd0 : 16'($urandom % d);
            1: n = 16'($urandom);
            2: begin
               d = 16'($urandom_range(0, 40));
               n = 16'($urandom_range(0, 40));
            end
            default: n = (d == 16'd0) ? 16'd0 : d - 16'd1;
         endcase
         run_div(n, d, 1'b1, $sformatf("rand%0d_%0d_%0d", i, n, d));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
